dem_dither_quantizer: RTL
=========================

# dem_dither_quantizer

Upstream front end of the DEM-DAC datapath. Accepts 16-bit unsigned samples, adds optional LFSR dither, and requantizes them to a 3-bit level (0..7) with first-order error feedback. The level feeds the switching-block tree. A valid/ready handshake on both sides carries the data, and the block keeps a saturating clip counter for diagnostics.

## Interface
Parameters:
- INPUT_WIDTH, 16, sample width, unsigned
- OUTPUT_WIDTH, 3, level width
- LFSR_INIT, 8'hFF, LFSR reset seed; must be nonzero

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  sample present
- in_ready  out  1  block can accept
- in_sample  in  INPUT_WIDTH  unsigned sample
- out_valid  out  1  level present
- out_ready  in  1  downstream accepts
- out_level  out  OUTPUT_WIDTH  quantized level 0..MAX_LEVEL
- out_sat  out  1  level was clipped (high or low)
- sat_count  out  16  clipped-sample count, saturates at 16'hFFFF

## Operation
- Accept occurs when in_valid && in_ready. Emit occurs when out_valid && out_ready.
- in_ready = !out_valid || out_ready. This is a combinational pass-through of out_ready, with a single output register.
- On accept, the block computes in 19-bit signed arithmetic:
  - d = ({lfsr,4'b0}) - 2048, giving dither range -2048..+2032.
  - v = in_sample + err + d.
  - qraw = v >>> 13, an arithmetic shift; QUANT_STEP = 8192.
- Clipping:
  - If qraw > 7: level = 7, out_sat = 1, err <= 0.
  - If qraw < 0: level = 0, out_sat = 1, err <= 0.
  - Otherwise: level = qraw, out_sat = 0, err <= v[12:0], which lies in 0..8191.
- err is a 13-bit unsigned state register. It updates only on accept.
- LFSR:
  - 8-bit Fibonacci, shift left, bit0 <= lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3] (maximal, period 255).
  - It advances once per accept, and never on idle or stall.
  - v uses the pre-advance value.
- sat_count increments on each accept that clips, and holds at 16'hFFFF.
- Stall: while out_valid && !out_ready, out_level and out_sat hold, and err, LFSR and sat_count freeze.
- out_valid is set on accept. It is cleared on an emit without a simultaneous accept. Emit and accept in the same cycle replaces the output; out_valid stays 1.

## Timing
- Latency is 1 cycle: the sample accepted at edge N appears on out_level after edge N.
- Throughput is one sample per clock when out_ready = 1.
- Reset values: out_valid 0, out_level 0, out_sat 0, sat_count 0, err 0, lfsr LFSR_INIT. in_ready is 1 one cycle after reset is applied.
- Reset mid-stream drops any held output without emitting it. The state restarts as after power-up, and rst has priority over accept.
- While rst = 1, in_ready still follows its equation, but no accept takes effect.

## Configuration
- DEM_DITHER_EN defined: the dither path and LFSR operate as above.
- DEM_DITHER_EN undefined: d = 0, the LFSR is not instantiated, and the quantizer is a pure first-order error-feedback quantizer. Outputs are bit-exact deterministic.

## Structure
- Shared package holds:
  - QUANT_STEP, MAX_LEVEL and LFSR_INIT.
  - New constants ERR_WIDTH = 13, DITHER_SHIFT = 4, DITHER_OFFSET = 2048 and SAT_CNT_WIDTH = 16.
  - New constant LFSR_TAP_MASK = 8'hB8, taps 7, 5, 4, 3.
- Sub-module dem_lfsr8 contains the LFSR register, seed and advance enable. It is reused by the switching blocks for their own randomization.

## Test plan
- Dither off; in_sample 16'h2000 held, out_ready 1, 8 accepts -> out_level 1 every sample, err 0, sat_count 0.
- Dither off; in_sample 16'h3000 held -> out_level 1, 2, 1, 2..., err alternating 16'h1000 and 0.
- Dither off; in_sample 16'hFFFF held -> out_level 7 every sample, out_sat 0, 1, 0, 1, and sat_count 2 after 4 samples.
- Dither on; 5 accepts from reset -> LFSR states FF, FE, FC, F8, F0, E1, with v matching the formula for each sample.
- Backpressure: out_ready 0 for 5 cycles with in_valid 1 -> in_ready 0, out_level stable, LFSR and err unchanged. Releasing out_ready yields exactly one emit per cycle with no lost sample.
- rst asserted for 1 cycle between two accepts -> out_valid 0 next cycle, sat_count 0, err 0, and the LFSR back at FF.

Source files
------------

// File: rtl/dem_dither_quantizer_pkg.sv
// Shared constants for the DEM-DAC front-end quantizer and the LFSR used
// for dither and switching-block randomization.
package dem_dither_quantizer_pkg;

  // Requantizer step and top output level
  localparam int unsigned QUANT_SHIFT   = 13;
  localparam int unsigned QUANT_STEP    = 1 << QUANT_SHIFT;
  localparam int unsigned MAX_LEVEL     = 7;

  // Error-feedback state holds the residue of one quantizer step
  localparam int unsigned ERR_WIDTH     = QUANT_SHIFT;

  // Dither is {lfsr, 4'b0} re-centred around zero
  localparam int unsigned DITHER_SHIFT  = 4;
  localparam int unsigned DITHER_OFFSET = 2048;

  // Diagnostic clip counter width
  localparam int unsigned SAT_CNT_WIDTH = 16;

  // 8-bit maximal-length Fibonacci LFSR: taps 7, 5, 4, 3
  localparam logic [7:0]  LFSR_INIT     = 8'hFF;
  localparam logic [7:0]  LFSR_TAP_MASK = 8'hB8;

  // Feedback bit of the LFSR for a given state
  function automatic logic lfsr_feedback(input logic [7:0] state);
    return ^(state & LFSR_TAP_MASK);
  endfunction

endpackage

// File: rtl/dem_lfsr8.sv
// 8-bit Fibonacci LFSR with programmable seed and advance enable.
// Shifts left; the new bit 0 is the XOR of the tapped bits.
module dem_lfsr8
  import dem_dither_quantizer_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_en,
  output logic [7:0] o_state
);

  logic [7:0] r_state;

  // Advance one step per enabled cycle; reload the seed on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= SEED;
    end else if (i_en) begin
      r_state <= {r_state[6:0], lfsr_feedback(r_state)};
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/dem_dither_quantizer.sv
// Front end of the DEM-DAC datapath: optional LFSR dither plus first-order
// error-feedback requantization of unsigned samples to a small level.
// Optional feature macro: DEM_DITHER_EN (defined -> dither path and LFSR
// present; undefined -> dither is zero and no LFSR is built).
module dem_dither_quantizer
  import dem_dither_quantizer_pkg::*;
#(
  parameter int unsigned INPUT_WIDTH  = 16,
  parameter int unsigned OUTPUT_WIDTH = 3,
  parameter logic [7:0]  LFSR_INIT    = dem_dither_quantizer_pkg::LFSR_INIT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [INPUT_WIDTH-1:0]   in_sample,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUTPUT_WIDTH-1:0]  out_level,
  output logic                     out_sat,
  output logic [SAT_CNT_WIDTH-1:0] sat_count
);

  // Three guard bits cover sample + residue + dither without overflow
  localparam int unsigned V_WIDTH = INPUT_WIDTH + 3;

  logic                     r_out_valid;
  logic [OUTPUT_WIDTH-1:0]  r_out_level;
  logic                     r_out_sat;
  logic [SAT_CNT_WIDTH-1:0] r_sat_count;
  logic [ERR_WIDTH-1:0]     r_err;

  logic                     w_accept;
  logic                     w_emit;
  logic signed [V_WIDTH-1:0] w_dither;
  logic signed [V_WIDTH-1:0] w_v;
  logic signed [V_WIDTH-1:0] w_qraw;
  logic                     w_clip_hi;
  logic                     w_clip_lo;

  // Single output register: upstream may push whenever the slot frees up
  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;
  assign w_emit   = r_out_valid && out_ready;

`ifdef DEM_DITHER_EN
  logic [7:0] w_lfsr;

  // LFSR steps only on accepted samples so the dither sequence is stall-proof
  dem_lfsr8 #(
    .SEED (LFSR_INIT)
  ) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_accept),
    .o_state (w_lfsr)
  );

  // Pre-advance LFSR value scaled and centred: -2048 .. +2032
  assign w_dither = $signed({{(V_WIDTH-8-DITHER_SHIFT){1'b0}}, w_lfsr, {DITHER_SHIFT{1'b0}}})
                  - $signed(V_WIDTH'(DITHER_OFFSET));
`else
  assign w_dither = '0;
`endif

  // Quantizer input: sample plus carried residue plus dither
  assign w_v = $signed({3'b000, in_sample})
             + $signed({{(V_WIDTH-ERR_WIDTH){1'b0}}, r_err})
             + w_dither;

  assign w_qraw    = w_v >>> QUANT_SHIFT;
  assign w_clip_hi = w_qraw > $signed(V_WIDTH'(MAX_LEVEL));
  assign w_clip_lo = w_qraw < $signed(V_WIDTH'(0));

  // Output register, residue and clip counter update on accept; reset wins
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_level <= '0;
      r_out_sat   <= 1'b0;
      r_sat_count <= '0;
      r_err       <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      if (w_clip_hi) begin
        r_out_level <= OUTPUT_WIDTH'(MAX_LEVEL);
        r_out_sat   <= 1'b1;
        r_err       <= '0;
      end else if (w_clip_lo) begin
        r_out_level <= '0;
        r_out_sat   <= 1'b1;
        r_err       <= '0;
      end else begin
        r_out_level <= w_qraw[OUTPUT_WIDTH-1:0];
        r_out_sat   <= 1'b0;
        r_err       <= w_v[ERR_WIDTH-1:0];
      end
      if ((w_clip_hi || w_clip_lo) && (r_sat_count != '1)) begin
        r_sat_count <= r_sat_count + 1'b1;
      end
    end else if (w_emit) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_level = r_out_level;
  assign out_sat   = r_out_sat;
  assign sat_count = r_sat_count;

endmodule
